// File: rtl/wakeup_issue_queue_if.sv
// -----------------------------------------------------------------------------
// wakeup_issue_queue_if
// Bundles the dispatch, wakeup-broadcast and issue-lane signals of the wakeup
// issue queue, plus its flush/stall controls and the occupancy count.
//   master : the environment (dispatch stage, wakeup sources, back end)
//   slave  : the issue queue itself
// Parameters must match the ones given to wakeup_issue_queue; CNT_W is
// $clog2(IQ_SIZE)+1.
// -----------------------------------------------------------------------------
interface wakeup_issue_queue_if #(
  parameter int ISSUE_PORTS = 2,
  parameter int WAKE_PORTS  = 2,
  parameter int PREG_W      = 6,
  parameter int ROB_W       = 5,
  parameter int UOP_W       = 5,
  parameter int CNT_W       = 5
);
  logic                          flush;
  logic                          stall_in;
  logic                          in_valid;
  logic                          in_ready;
  logic [ROB_W-1:0]              rob_index;
  logic [UOP_W-1:0]              uop;
  logic [PREG_W-1:0]             prs1;
  logic [PREG_W-1:0]             prs2;
  logic                          prs1_rdy;
  logic                          prs2_rdy;
  logic [PREG_W-1:0]             prd;
  logic [31:0]                   imm;
  logic [WAKE_PORTS-1:0]         wake_valid;
  logic [WAKE_PORTS*PREG_W-1:0]  wake_tag;
  logic [ISSUE_PORTS-1:0]        out_valid;
  logic [ISSUE_PORTS*ROB_W-1:0]  out_rob_index;
  logic [ISSUE_PORTS*UOP_W-1:0]  out_uop;
  logic [ISSUE_PORTS*PREG_W-1:0] out_prs1;
  logic [ISSUE_PORTS*PREG_W-1:0] out_prs2;
  logic [ISSUE_PORTS*PREG_W-1:0] out_prd;
  logic [ISSUE_PORTS*32-1:0]     out_imm;
  logic [CNT_W-1:0]              count;

  modport master (
    output flush, stall_in, in_valid, rob_index, uop, prs1, prs2, prs1_rdy,
           prs2_rdy, prd, imm, wake_valid, wake_tag,
    input  in_ready, out_valid, out_rob_index, out_uop, out_prs1, out_prs2,
           out_prd, out_imm, count
  );

  modport slave (
    input  flush, stall_in, in_valid, rob_index, uop, prs1, prs2, prs1_rdy,
           prs2_rdy, prd, imm, wake_valid, wake_tag,
    output in_ready, out_valid, out_rob_index, out_uop, out_prs1, out_prs2,
           out_prd, out_imm, count
  );
endinterface

// File: rtl/wakeup_issue_queue.sv
// -----------------------------------------------------------------------------
// wakeup_issue_queue
// Out-of-order issue queue between rename/dispatch and the execution units.
// Holds up to IQ_SIZE micro-ops, tracks per-source readiness updated by
// WAKE_PORTS tag broadcasts, and each cycle selects up to ISSUE_PORTS ready
// entries onto registered output lanes (issue latency 1).
//
// Ports
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : wakeup_issue_queue_if.slave
//          flush/stall_in, dispatch (in_valid/in_ready + op fields),
//          wakeup (wake_valid/wake_tag), issue lanes (out_*), count
//
// Configuration macro
//   ISSUE_OLDEST_FIRST_EN : select by dispatch age using an IQ_SIZE x IQ_SIZE
//                           age matrix. Undefined: lowest slot index first.
// -----------------------------------------------------------------------------
module wakeup_issue_queue #(
  parameter int IQ_SIZE     = 16,
  parameter int ISSUE_PORTS = 2,
  parameter int WAKE_PORTS  = 2,
  parameter int PREG_W      = 6,
  parameter int ROB_W       = 5,
  parameter int UOP_W       = 5
) (
  input logic               clk,
  input logic               rst,
  wakeup_issue_queue_if.slave bus
);
  localparam int IDX_W = $clog2(IQ_SIZE);
  localparam int CNT_W = IDX_W + 1;

  // entry state
  logic [IQ_SIZE-1:0] valid_q, rdy1_q, rdy2_q;
  logic [ROB_W-1:0]   rob_q  [IQ_SIZE];
  logic [UOP_W-1:0]   uop_q  [IQ_SIZE];
  logic [PREG_W-1:0]  prs1_q [IQ_SIZE];
  logic [PREG_W-1:0]  prs2_q [IQ_SIZE];
  logic [PREG_W-1:0]  prd_q  [IQ_SIZE];
  logic [31:0]        imm_q  [IQ_SIZE];
  logic [CNT_W-1:0]   count_q;

`ifdef ISSUE_OLDEST_FIRST_EN
  // age_q[i][j] = 1 : entry j was dispatched before entry i
  logic [IQ_SIZE-1:0] age_q [IQ_SIZE];
`endif

  // registered issue lanes
  logic [ISSUE_PORTS-1:0]        out_valid_q;
  logic [ISSUE_PORTS*ROB_W-1:0]  out_rob_q;
  logic [ISSUE_PORTS*UOP_W-1:0]  out_uop_q;
  logic [ISSUE_PORTS*PREG_W-1:0] out_prs1_q, out_prs2_q, out_prd_q;
  logic [ISSUE_PORTS*32-1:0]     out_imm_q;

  logic                   accept, do_select, alloc_found, head;
  logic                   src1_rdy_in, src2_rdy_in;
  logic [IDX_W-1:0]       alloc_idx;
  logic [IQ_SIZE-1:0]     eligible, wake1, wake2, remaining, grant_mask;
  logic [ISSUE_PORTS-1:0] grant_vld;
  logic [IDX_W-1:0]       grant_idx [ISSUE_PORTS];
  logic [CNT_W-1:0]       n_issued;

  function automatic logic tag_hit(input logic [PREG_W-1:0]            tag,
                                   input logic [WAKE_PORTS-1:0]        wv,
                                   input logic [WAKE_PORTS*PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++)
      if (wv[k] && (wt[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  // in_ready comes from the registered count, so slots freed this cycle are
  // only reusable next cycle.
  assign bus.in_ready = (count_q != CNT_W'(IQ_SIZE));
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign do_select    = ~bus.stall_in & ~bus.flush;
  assign eligible     = valid_q & rdy1_q & rdy2_q;

  assign src1_rdy_in = bus.prs1_rdy | (bus.prs1 == '0) |
                       tag_hit(bus.prs1, bus.wake_valid, bus.wake_tag);
  assign src2_rdy_in = bus.prs2_rdy | (bus.prs2 == '0) |
                       tag_hit(bus.prs2, bus.wake_valid, bus.wake_tag);

  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      wake1[i] = tag_hit(prs1_q[i], bus.wake_valid, bus.wake_tag);
      wake2[i] = tag_hit(prs2_q[i], bus.wake_valid, bus.wake_tag);
    end
  end

  // lowest free slot; one always exists whenever in_ready is high
  always_comb begin
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_idx   = IDX_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  // Lane l takes the first candidate still remaining; a granted entry is
  // removed from the pool so it cannot reach another lane.
  always_comb begin
    remaining  = do_select ? eligible : '0;
    grant_mask = '0;
    grant_vld  = '0;
    n_issued   = '0;
    head       = 1'b0;
    for (int l = 0; l < ISSUE_PORTS; l++) begin
      grant_idx[l] = '0;
      for (int i = 0; i < IQ_SIZE; i++) begin
`ifdef ISSUE_OLDEST_FIRST_EN
        // oldest remaining entry: nothing else remaining is older than it
        head = ((age_q[i] & remaining) == '0);
`else
        head = 1'b1;
`endif
        if (!grant_vld[l] && remaining[i] && head) begin
          grant_vld[l]  = 1'b1;
          grant_idx[l]  = IDX_W'(i);
          grant_mask[i] = 1'b1;
          remaining[i]  = 1'b0;
        end
      end
      n_issued = n_issued + CNT_W'(grant_vld[l]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      // wakes on free slots are harmless: allocation overwrites the rdy bits
      rdy1_q  <= rdy1_q | wake1;
      rdy2_q  <= rdy2_q | wake2;
      valid_q <= valid_q & ~grant_mask;
      if (accept) begin
        valid_q[alloc_idx] <= 1'b1;
        rdy1_q[alloc_idx]  <= src1_rdy_in;
        rdy2_q[alloc_idx]  <= src2_rdy_in;
      end
      count_q <= count_q + CNT_W'(accept) - n_issued;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rob_q[alloc_idx]  <= bus.rob_index;
      uop_q[alloc_idx]  <= bus.uop;
      prs1_q[alloc_idx] <= bus.prs1;
      prs2_q[alloc_idx] <= bus.prs2;
      prd_q[alloc_idx]  <= bus.prd;
      imm_q[alloc_idx]  <= bus.imm;
    end
  end

`ifdef ISSUE_OLDEST_FIRST_EN
  // New row = everything still valid after this edge's frees; freed entries
  // drop out of every row by clearing their column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IQ_SIZE; i++) age_q[i] <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < IQ_SIZE; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < IQ_SIZE; i++) begin
        if (accept && (alloc_idx == IDX_W'(i)))
          age_q[i] <= valid_q & ~grant_mask;
        else
          age_q[i] <= age_q[i] & ~grant_mask;
      end
    end
  end
`endif

  // lane data holds on flush, stall, and for unused lanes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_rob_q   <= '0;
      out_uop_q   <= '0;
      out_prs1_q  <= '0;
      out_prs2_q  <= '0;
      out_prd_q   <= '0;
      out_imm_q   <= '0;
    end else if (bus.flush) begin
      out_valid_q <= '0;
    end else if (!bus.stall_in) begin
      out_valid_q <= grant_vld;
      for (int l = 0; l < ISSUE_PORTS; l++) begin
        if (grant_vld[l]) begin
          out_rob_q[l*ROB_W +: ROB_W]    <= rob_q[grant_idx[l]];
          out_uop_q[l*UOP_W +: UOP_W]    <= uop_q[grant_idx[l]];
          out_prs1_q[l*PREG_W +: PREG_W] <= prs1_q[grant_idx[l]];
          out_prs2_q[l*PREG_W +: PREG_W] <= prs2_q[grant_idx[l]];
          out_prd_q[l*PREG_W +: PREG_W]  <= prd_q[grant_idx[l]];
          out_imm_q[l*32 +: 32]          <= imm_q[grant_idx[l]];
        end
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_rob_index = out_rob_q;
  assign bus.out_uop       = out_uop_q;
  assign bus.out_prs1      = out_prs1_q;
  assign bus.out_prs2      = out_prs2_q;
  assign bus.out_prd       = out_prd_q;
  assign bus.out_imm       = out_imm_q;
  assign bus.count         = count_q;

endmodule

// File: tb/tb_wakeup_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_wakeup_issue_queue
// Directed scenarios followed by randomized dispatch/wakeup/stall/flush traffic.
// A behavioural model (array of entries, dispatch sequence numbers) predicts
// each edge's issues and count; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_wakeup_issue_queue;
  localparam int IQ = 16, IP = 2, WP = 2, PW = 6, RW = 5, UW = 5, CW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wakeup_issue_queue_if #(.ISSUE_PORTS(IP), .WAKE_PORTS(WP), .PREG_W(PW),
                          .ROB_W(RW), .UOP_W(UW), .CNT_W(CW)) bus ();

  wakeup_issue_queue #(.IQ_SIZE(IQ), .ISSUE_PORTS(IP), .WAKE_PORTS(WP),
                       .PREG_W(PW), .ROB_W(RW), .UOP_W(UW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic v, r1, r2;
    logic [RW-1:0] rob;
    logic [UW-1:0] uop;
    logic [PW-1:0] p1, p2, pd;
    logic [31:0]   imm;
    int unsigned   seq;
  } ent_t;

  typedef struct {
    int            lane;
    logic [RW-1:0] rob;
    logic [UW-1:0] uop;
    logic [PW-1:0] p1, p2, pd;
    logic [31:0]   imm;
  } iss_t;

  ent_t        m [IQ];
  iss_t        exp_q [$];
  int          exp_cnt_q [$];
  int          m_cnt = 0;
  int unsigned seq_ctr = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit woke(input logic [PW-1:0] t);
    for (int k = 0; k < WP; k++)
      if (bus.wake_valid[k] && bus.wake_tag[k*PW +: PW] == t) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    ent_t pre [IQ];
    bit   taken [IQ];
    int   best, slot, nis;
    bit   better;
    iss_t e;
    if (rst) begin
      for (int i = 0; i < IQ; i++) m[i].v = 1'b0;
      m_cnt = 0;
    end else if (bus.flush) begin
      for (int i = 0; i < IQ; i++) m[i].v = 1'b0;
      m_cnt = 0;
      exp_cnt_q.push_back(0);
    end else begin
      pre = m;
      nis = 0;
      for (int i = 0; i < IQ; i++) taken[i] = 1'b0;
      if (!bus.stall_in) begin
        for (int l = 0; l < IP; l++) begin
          best = -1;
          for (int i = 0; i < IQ; i++) begin
            if (pre[i].v && pre[i].r1 && pre[i].r2 && !taken[i]) begin
`ifdef ISSUE_OLDEST_FIRST_EN
              better = (best < 0) || (pre[i].seq < pre[best].seq);
`else
              better = (best < 0);
`endif
              if (better) best = i;
            end
          end
          if (best >= 0) begin
            taken[best] = 1'b1;
            e.lane = l;       e.rob = pre[best].rob; e.uop = pre[best].uop;
            e.p1 = pre[best].p1; e.p2 = pre[best].p2; e.pd = pre[best].pd;
            e.imm = pre[best].imm;
            exp_q.push_back(e);
            nis++;
          end
        end
      end
      for (int i = 0; i < IQ; i++) begin
        if (m[i].v && woke(m[i].p1)) m[i].r1 = 1'b1;
        if (m[i].v && woke(m[i].p2)) m[i].r2 = 1'b1;
      end
      if (bus.in_valid && m_cnt < IQ) begin
        slot = -1;
        for (int i = 0; i < IQ; i++) if (!pre[i].v && slot < 0) slot = i;
        m[slot].v   = 1'b1;
        m[slot].r1  = bus.prs1_rdy || bus.prs1 == 0 || woke(bus.prs1);
        m[slot].r2  = bus.prs2_rdy || bus.prs2 == 0 || woke(bus.prs2);
        m[slot].rob = bus.rob_index; m[slot].uop = bus.uop;
        m[slot].p1  = bus.prs1;      m[slot].p2  = bus.prs2;
        m[slot].pd  = bus.prd;       m[slot].imm = bus.imm;
        m[slot].seq = seq_ctr++;
        m_cnt++;
      end
      for (int i = 0; i < IQ; i++) if (taken[i]) m[i].v = 1'b0;
      m_cnt = m_cnt - nis;
      exp_cnt_q.push_back(m_cnt);
    end
  end

  // ---------------- monitor ----------------
  logic rst_s = 1'b1, stall_s = 1'b0, flush_s = 1'b0;
  always @(posedge clk) begin
    rst_s   <= rst;
    stall_s <= bus.stall_in;
    flush_s <= bus.flush;
  end

  always @(negedge clk) begin
    iss_t          e;
    logic [IP-1:0] seen;
    int            c;
    if (rst_s === 1'b0) begin
      seen = '0;
      if (exp_cnt_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL count_sb: no expected count queued at %0t", $time);
      end else begin
        c = exp_cnt_q.pop_front();
        chk("count", 64'(bus.count), 64'(c));
        chk("in_ready", 64'(bus.in_ready), 64'(c != IQ));
      end
      if (flush_s) begin
        chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
        exp_q.delete();
      end else if (!stall_s) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          seen[e.lane] = 1'b1;
          chk("lane_valid", 64'(bus.out_valid[e.lane]), 64'(1));
          chk("lane_rob",  64'(bus.out_rob_index[e.lane*RW +: RW]), 64'(e.rob));
          chk("lane_uop",  64'(bus.out_uop[e.lane*UW +: UW]),       64'(e.uop));
          chk("lane_prs1", 64'(bus.out_prs1[e.lane*PW +: PW]),      64'(e.p1));
          chk("lane_prs2", 64'(bus.out_prs2[e.lane*PW +: PW]),      64'(e.p2));
          chk("lane_prd",  64'(bus.out_prd[e.lane*PW +: PW]),       64'(e.pd));
          chk("lane_imm",  64'(bus.out_imm[e.lane*32 +: 32]),       64'(e.imm));
        end
        for (int l = 0; l < IP; l++)
          if (!seen[l]) chk("idle_lane", 64'(bus.out_valid[l]), 64'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    bus.in_valid   = 1'b0;
    bus.wake_valid = '0;
    bus.flush      = 1'b0;
    bus.stall_in   = 1'b0;
  endtask

  task automatic disp(input int rob, input int p1, input bit r1, input int p2, input bit r2);
    bus.in_valid  = 1'b1;
    bus.rob_index = RW'(rob);
    bus.uop       = UW'($urandom);
    bus.prs1      = PW'(p1);
    bus.prs1_rdy  = r1;
    bus.prs2      = PW'(p2);
    bus.prs2_rdy  = r2;
    bus.prd       = PW'($urandom);
    bus.imm       = $urandom;
  endtask

  task automatic wake_one(input int t);
    bus.wake_valid = 2'b01;
    bus.wake_tag   = {PW'(0), PW'(t)};
  endtask

  initial begin
    quiet();
    bus.rob_index = '0; bus.uop = '0; bus.prs1 = '0; bus.prs2 = '0;
    bus.prs1_rdy = 1'b0; bus.prs2_rdy = 1'b0; bus.prd = '0; bus.imm = '0;
    bus.wake_tag = '0;
    rst = 1'b1;
    step(); step();
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_rob", 64'(bus.out_rob_index), 64'(0));
    chk("rst_out_imm", 64'(bus.out_imm), 64'(0));
    rst = 1'b0;

    // 1: ready op issues two edges after dispatch
    disp(3, 1, 1, 2, 1); step();
    quiet(); step();
    chk("t1_valid", 64'(bus.out_valid[0]), 64'(1));
    chk("t1_rob", 64'(bus.out_rob_index[RW-1:0]), 64'(3));
    chk("t1_count", 64'(bus.count), 64'(0));
    step();

    // 2: woken in cycle t, issues at t+2
    disp(4, 7, 0, 0, 0); step();
    quiet(); step();
    wake_one(7); step();
    quiet();
    chk("t2_not_early", 64'(bus.out_valid), 64'(0));
    step();
    chk("t2_valid", 64'(bus.out_valid[0]), 64'(1));
    chk("t2_rob", 64'(bus.out_rob_index[RW-1:0]), 64'(4));

    // 3: same-cycle wake captured at dispatch
    disp(5, 0, 1, 9, 0); wake_one(9); step();
    quiet(); step();
    chk("t3_valid", 64'(bus.out_valid[0]), 64'(1));
    chk("t3_rob", 64'(bus.out_rob_index[RW-1:0]), 64'(5));

    // 4: fill, reject when full, wake all, drain two per cycle
    for (int i = 0; i < IQ; i++) begin disp(i, 20, 0, 21, 0); step(); end
    quiet();
    chk("t4_full_count", 64'(bus.count), 64'(IQ));
    chk("t4_in_ready", 64'(bus.in_ready), 64'(0));
    disp(31, 0, 1, 0, 1); step();
    quiet();
    chk("t4_drop", 64'(bus.count), 64'(IQ));
    bus.wake_valid = 2'b11; bus.wake_tag = {PW'(21), PW'(20)}; step();
    quiet();
    for (int c = 0; c < IQ / IP; c++) begin
      step();
      chk("t4_both_lanes", 64'(bus.out_valid), 64'(2'b11));
    end
    chk("t4_drained", 64'(bus.count), 64'(0));

    // 5: flush drops queue and same-cycle dispatch
    for (int i = 0; i < 5; i++) begin disp(i + 8, 30, 0, 30, 0); step(); end
    disp(9, 0, 1, 0, 1); bus.flush = 1'b1; step();
    quiet();
    chk("t5_count", 64'(bus.count), 64'(0));
    chk("t5_out_valid", 64'(bus.out_valid), 64'(0));
    wake_one(30); step();
    quiet();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_no_issue", 64'(bus.out_valid), 64'(0));
    end

    // 6: age order vs slot order
    disp(10, 0, 1, 0, 1); step();
    disp(11, 41, 0, 0, 1); step();
    disp(12, 41, 0, 0, 1); step();
    quiet(); wake_one(41); step();
    quiet(); step();
    chk("t6_valid", 64'(bus.out_valid), 64'(2'b11));
`ifdef ISSUE_OLDEST_FIRST_EN
    chk("t6_lane0", 64'(bus.out_rob_index[0 +: RW]), 64'(11));
    chk("t6_lane1", 64'(bus.out_rob_index[RW +: RW]), 64'(12));
`else
    chk("t6_lane0", 64'(bus.out_rob_index[0 +: RW]), 64'(12));
    chk("t6_lane1", 64'(bus.out_rob_index[RW +: RW]), 64'(11));
`endif

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      quiet();
      if ($urandom_range(0, 99) < 60)
        disp($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 99) < 25,
             $urandom_range(0, 15), $urandom_range(0, 99) < 25);
      bus.wake_valid = WP'($urandom);
      bus.wake_tag   = {PW'($urandom_range(0, 15)), PW'($urandom_range(0, 15))};
      bus.stall_in   = ($urandom_range(0, 99) < 20);
      bus.flush      = ($urandom_range(0, 99) < 2);
      step();
    end
    quiet();
    for (int n = 0; n < 20; n++) begin
      bus.wake_valid = 2'b11;
      bus.wake_tag   = {PW'($urandom_range(0, 15)), PW'($urandom_range(0, 15))};
      step();
    end
    quiet();
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
